iob_ram_be_arbiter: RTL and testbench

- Shares one port of a byte-enable RAM (NUM_COL columns of COL_W bits, one-cycle registered read) between two requesters, r0 and r1.
- Arbitration is round-robin with a bounded burst hold.
- One access per cycle, fully pipelined.
- Read data is returned to the requester that issued the read.
- Sits between two masters (e.g. CPU data bus and a DMA engine) and either port of the true dual-port byte-enable RAM.

---
 rtl/iob_ram_be_arbiter.sv | 134 +++++++++++++
 tb/tb_iob_ram_be_arbiter.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iob_ram_be_arbiter.sv
// iob_ram_be_arbiter: shares one port of a byte-enable RAM between two
// requesters (r0, r1). Round-robin arbitration with a bounded burst hold.
// One access per cycle. Read data returns to the issuing requester one
// cycle after acceptance.
// Optional macro IOB_RAM_ARB_FIXED_PRIO_EN: r0 always wins contention and
// the round-robin/burst state is not built.
module iob_ram_be_arbiter #(
    parameter int NUM_COL   = 4,
    parameter int COL_W     = 8,
    parameter int DATA_W    = NUM_COL * COL_W,
    parameter int ADDR_W    = 10,
    parameter int MAX_BURST = 4
) (
    input  logic               clk,
    input  logic               rst,

    input  logic               r0_valid,
    input  logic [ADDR_W-1:0]  r0_addr,
    input  logic [DATA_W-1:0]  r0_wdata,
    input  logic [NUM_COL-1:0] r0_wstrb,
    output logic               r0_ready,
    output logic               r0_rvalid,
    output logic [DATA_W-1:0]  r0_rdata,

    input  logic               r1_valid,
    input  logic [ADDR_W-1:0]  r1_addr,
    input  logic [DATA_W-1:0]  r1_wdata,
    input  logic [NUM_COL-1:0] r1_wstrb,
    output logic               r1_ready,
    output logic               r1_rvalid,
    output logic [DATA_W-1:0]  r1_rdata,

    output logic               ram_en,
    output logic [NUM_COL-1:0] ram_we,
    output logic [ADDR_W-1:0]  ram_addr,
    output logic [DATA_W-1:0]  ram_din,
    input  logic [DATA_W-1:0]  ram_dout
);
    // Read tag encodings: {read pending, requester id}
    localparam logic [1:0] TAG_R0 = 2'b10;
    localparam logic [1:0] TAG_R1 = 2'b11;

    if (DATA_W != NUM_COL * COL_W) begin : gWidthCheck
        $error("iob_ram_be_arbiter: DATA_W must equal NUM_COL*COL_W");
    end

    logic       anyWin;   // some request is granted this cycle
    logic       winId;    // granted requester: 0 = r0, 1 = r1
    logic [1:0] rtag;

    assign anyWin = ~rst & (r0_valid | r1_valid);

`ifdef IOB_RAM_ARB_FIXED_PRIO_EN
    // Fixed priority: r1 is granted only when r0 is not requesting
    always_comb begin
        winId = r1_valid & ~r0_valid;
    end
`else
    localparam logic [7:0] BURST_LIM = 8'(MAX_BURST);
    localparam logic [7:0] BCNT_SAT  = 8'hFF;

    logic       prio;
    logic       last;
    logic [7:0] bcnt;
    logic       burstHold;

    // Pick the winner; bcnt is non-zero exactly when the previous cycle
    // granted someone, so it doubles as the "granted last cycle" flag
    always_comb begin
        burstHold = (bcnt != 8'd0) && (bcnt < BURST_LIM);
        if (r0_valid && r1_valid) begin
            winId = burstHold ? last : prio;
        end else begin
            winId = r1_valid;
        end
    end

    // Round-robin pointer, last winner and saturating burst counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio <= 1'b0;
            last <= 1'b0;
            bcnt <= 8'd0;
        end else if (anyWin) begin
            last <= winId;
            prio <= ~winId;
            if ((winId == last) && (bcnt != 8'd0)) begin
                bcnt <= (bcnt == BCNT_SAT) ? bcnt : bcnt + 8'd1;
            end else begin
                bcnt <= 8'd1;
            end
        end else begin
            bcnt <= 8'd0;
        end
    end
`endif

    // Route the winner's request onto the RAM port
    always_comb begin
        ram_en   = anyWin;
        ram_we   = '0;
        ram_addr = '0;
        ram_din  = '0;
        if (anyWin) begin
            if (winId) begin
                ram_we   = r1_wstrb;
                ram_addr = r1_addr;
                ram_din  = r1_wdata;
            end else begin
                ram_we   = r0_wstrb;
                ram_addr = r0_addr;
                ram_din  = r0_wdata;
            end
        end
    end

    assign r0_ready = anyWin & ~winId;
    assign r1_ready = anyWin &  winId;

    // Remember who issued an accepted read so the data is steered back
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rtag <= 2'b00;
        end else begin
            rtag <= {anyWin && (ram_we == '0), winId};
        end
    end

    assign r0_rvalid = (rtag == TAG_R0);
    assign r1_rvalid = (rtag == TAG_R1);
    assign r0_rdata  = r0_rvalid ? ram_dout : '0;
    assign r1_rdata  = r1_rvalid ? ram_dout : '0;

endmodule

// File: tb/tb_iob_ram_be_arbiter.sv
// Testbench for iob_ram_be_arbiter: two instances (MAX_BURST=4 and
// MAX_BURST=1) share one stimulus set, each with its own RAM model.
// Honours IOB_RAM_ARB_FIXED_PRIO_EN for the expected grant rule.
module tb_iob_ram_be_arbiter;
    localparam int NC = 2;
    localparam int CW = 4;
    localparam int DW = NC * CW;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          r0_valid, r1_valid;
    logic [AW-1:0] r0_addr, r1_addr;
    logic [DW-1:0] r0_wdata, r1_wdata;
    logic [NC-1:0] r0_wstrb, r1_wstrb;

    logic          aR0Ready, aR1Ready, aR0Rvalid, aR1Rvalid, aRamEn;
    logic [DW-1:0] aR0Rdata, aR1Rdata, aRamDin, aRamDout;
    logic [NC-1:0] aRamWe;
    logic [AW-1:0] aRamAddr;
    logic          bR0Ready, bR1Ready, bR0Rvalid, bR1Rvalid, bRamEn;
    logic [DW-1:0] bR0Rdata, bR1Rdata, bRamDin, bRamDout;
    logic [NC-1:0] bRamWe;
    logic [AW-1:0] bRamAddr;

    logic [DW-1:0] memA [16];
    logic [DW-1:0] memB [16];
    logic [DW-1:0] refMem [16];

    int passCnt  = 0;
    int totalCnt = 0;

    // Reference model state (grant history and pending read)
    int            mb;
    int            runLen;
    int            lastW;
    int            prioM;
    bit            pendV;
    int            pendId;
    logic [DW-1:0] pendData;

    iob_ram_be_arbiter #(.NUM_COL(NC), .COL_W(CW), .DATA_W(DW), .ADDR_W(AW), .MAX_BURST(4)) dutA (
        .clk(clk), .rst(rst),
        .r0_valid(r0_valid), .r0_addr(r0_addr), .r0_wdata(r0_wdata), .r0_wstrb(r0_wstrb),
        .r0_ready(aR0Ready), .r0_rvalid(aR0Rvalid), .r0_rdata(aR0Rdata),
        .r1_valid(r1_valid), .r1_addr(r1_addr), .r1_wdata(r1_wdata), .r1_wstrb(r1_wstrb),
        .r1_ready(aR1Ready), .r1_rvalid(aR1Rvalid), .r1_rdata(aR1Rdata),
        .ram_en(aRamEn), .ram_we(aRamWe), .ram_addr(aRamAddr), .ram_din(aRamDin), .ram_dout(aRamDout)
    );

    iob_ram_be_arbiter #(.NUM_COL(NC), .COL_W(CW), .DATA_W(DW), .ADDR_W(AW), .MAX_BURST(1)) dutB (
        .clk(clk), .rst(rst),
        .r0_valid(r0_valid), .r0_addr(r0_addr), .r0_wdata(r0_wdata), .r0_wstrb(r0_wstrb),
        .r0_ready(bR0Ready), .r0_rvalid(bR0Rvalid), .r0_rdata(bR0Rdata),
        .r1_valid(r1_valid), .r1_addr(r1_addr), .r1_wdata(r1_wdata), .r1_wstrb(r1_wstrb),
        .r1_ready(bR1Ready), .r1_rvalid(bR1Rvalid), .r1_rdata(bR1Rdata),
        .ram_en(bRamEn), .ram_we(bRamWe), .ram_addr(bRamAddr), .ram_din(bRamDin), .ram_dout(bRamDout)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] ramInit(input int i);
        return DW'(i * 29 + 7);
    endfunction

    // Byte-enable RAM models, reloaded with their initial image during reset
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) memA[i] <= ramInit(i);
        end else if (aRamEn) begin
            for (int c = 0; c < NC; c++)
                if (aRamWe[c]) memA[aRamAddr][c*CW +: CW] <= aRamDin[c*CW +: CW];
            aRamDout <= memA[aRamAddr];
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) memB[i] <= ramInit(i);
        end else if (bRamEn) begin
            for (int c = 0; c < NC; c++)
                if (bRamWe[c]) memB[bRamAddr][c*CW +: CW] <= bRamDin[c*CW +: CW];
            bRamDout <= memB[bRamAddr];
        end
    end

    // Expected winner from the arbitration rules: -1 none, 0 r0, 1 r1
    function automatic int expWinner(input bit v0, input bit v1);
        if (!v0 && !v1) return -1;
        if (!v1) return 0;
        if (!v0) return 1;
`ifdef IOB_RAM_ARB_FIXED_PRIO_EN
        return 0;
`else
        if (runLen > 0 && runLen < mb) return lastW;
        return prioM;
`endif
    endfunction

    // Advance the model by one cycle given the winner and its payload
    task automatic modelAccept(input int w, input logic [AW-1:0] addr,
                               input logic [DW-1:0] wdata, input logic [NC-1:0] strb);
        if (w < 0) begin
            runLen = 0;
            pendV  = 0;
        end else begin
            runLen = (w == lastW && runLen > 0) ? runLen + 1 : 1;
            lastW  = w;
            prioM  = 1 - w;
            if (strb == '0) begin
                pendV    = 1;
                pendId   = w;
                pendData = refMem[addr];
            end else begin
                pendV = 0;
                for (int c = 0; c < NC; c++)
                    if (strb[c]) refMem[addr][c*CW +: CW] = wdata[c*CW +: CW];
            end
        end
    endtask

    task automatic applyReset();
        rst = 1'b1;
        r0_valid = 0; r1_valid = 0;
        r0_addr = '0; r1_addr = '0; r0_wdata = '0; r1_wdata = '0; r0_wstrb = '0; r1_wstrb = '0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        for (int i = 0; i < 16; i++) refMem[i] = ramInit(i);
        runLen = 0; lastW = 0; prioM = 0; pendV = 0; pendId = 0; pendData = '0;
    endtask

    task automatic test_reset();
        applyReset();
        @(posedge clk); #1;
        r0_valid = 1; r0_addr = 4'd3; r0_wstrb = 2'b00;
        #3;
        totalCnt++;
        if ({aR0Ready, aR1Ready, aRamEn, aRamWe, aRamAddr} !== {1'b1, 1'b0, 1'b1, 2'b00, 4'd3})
            $display("FAIL reset_first_grant: got %b required %b", {aR0Ready, aR1Ready, aRamEn, aRamWe, aRamAddr}, {1'b1, 1'b0, 1'b1, 2'b00, 4'd3});
        else passCnt++;
        @(posedge clk); #1;
        r0_valid = 0; r1_valid = 1; r1_addr = 4'd7; r1_wstrb = 2'b11; r1_wdata = 8'hFF;
        #1;
        totalCnt++;
        if ({aR0Rvalid, aR1Rvalid, aR0Rdata} !== {1'b1, 1'b0, ramInit(3)})
            $display("FAIL reset_first_read: got %b %b %h required 1 0 %h", aR0Rvalid, aR1Rvalid, aR0Rdata, ramInit(3));
        else passCnt++;
        #1 rst = 1'b1;
        #1;
        totalCnt++;
        if ({aR0Ready, aR1Ready, aRamEn, aRamWe, aR0Rvalid, aR1Rvalid, aR0Rdata} !== '0)
            $display("FAIL reset_async: got %b required all zero", {aR0Ready, aR1Ready, aRamEn, aRamWe, aR0Rvalid, aR1Rvalid, aR0Rdata});
        else passCnt++;
        @(posedge clk); #1;
        totalCnt++;
        if ({aR0Ready, aR1Ready, aRamEn, aRamWe, aR0Rvalid, aR1Rvalid, bRamEn, bRamWe} !== '0)
            $display("FAIL reset_held: got %b required all zero", {aR0Ready, aR1Ready, aRamEn, aRamWe, aR0Rvalid, aR1Rvalid, bRamEn, bRamWe});
        else passCnt++;
        r1_valid = 0;
    endtask

    task automatic test_byte_enables();
        applyReset();
        @(posedge clk); #1;
        r0_valid = 1; r0_addr = 4'd5; r0_wdata = 8'hA5; r0_wstrb = 2'b11;
        #3;
        totalCnt++;
        if ({aR0Ready, aRamWe, aRamDin} !== {1'b1, 2'b11, 8'hA5})
            $display("FAIL be_full_write: got %b %b %h required 1 11 a5", aR0Ready, aRamWe, aRamDin);
        else passCnt++;
        @(posedge clk); #1;
        r0_wdata = 8'h3C; r0_wstrb = 2'b01;
        #3;
        totalCnt++;
        if ({aR0Ready, aRamWe, aRamDin} !== {1'b1, 2'b01, 8'h3C})
            $display("FAIL be_partial_write: got %b %b %h required 1 01 3c", aR0Ready, aRamWe, aRamDin);
        else passCnt++;
        @(posedge clk); #1;
        r0_valid = 0; r1_valid = 1; r1_addr = 4'd5; r1_wstrb = 2'b00;
        #3;
        totalCnt++;
        if ({aR0Ready, aR1Ready} !== 2'b01)
            $display("FAIL be_read_grant: got %b required 01", {aR0Ready, aR1Ready});
        else passCnt++;
        @(posedge clk); #1;
        r1_valid = 0;
        #3;
        totalCnt++;
        if ({aR0Rvalid, aR1Rvalid, aR0Rdata, aR1Rdata} !== {1'b0, 1'b1, 8'h00, 8'hAC})
            $display("FAIL be_read_data: got %b %b %h %h required 0 1 00 ac", aR0Rvalid, aR1Rvalid, aR0Rdata, aR1Rdata);
        else passCnt++;
    endtask

    // Continuous contention with reads; alt selects the MAX_BURST=1 instance
    task automatic test_contention(input bit alt);
        int            expW;
        int            prevW;
        logic [DW-1:0] prevData;
        logic [1:0]    g, rv;
        logic [DW-1:0] rd0, rd1;
        logic          en;
        applyReset();
        prevW = -1; prevData = '0;
        r0_wstrb = '0; r1_wstrb = '0;
        for (int k = 0; k < 16; k++) begin
            @(posedge clk); #1;
            if (k == 0 || prevW == 0) r0_addr = AW'($urandom);
            if (k == 0 || prevW == 1) r1_addr = AW'($urandom);
            r0_valid = 1; r1_valid = 1;
            #3;
            g   = alt ? {bR0Ready, bR1Ready} : {aR0Ready, aR1Ready};
            rv  = alt ? {bR0Rvalid, bR1Rvalid} : {aR0Rvalid, aR1Rvalid};
            rd0 = alt ? bR0Rdata : aR0Rdata;
            rd1 = alt ? bR1Rdata : aR1Rdata;
            en  = alt ? bRamEn : aRamEn;
`ifdef IOB_RAM_ARB_FIXED_PRIO_EN
            expW = 0;
`else
            expW = alt ? (k % 2) : ((k / 4) % 2);
`endif
            totalCnt++;
            if ({g, en} !== {expW == 0, expW == 1, 1'b1})
                $display("FAIL contention_grant alt=%0d k=%0d: got %b required %b", alt, k, {g, en}, {expW == 0, expW == 1, 1'b1});
            else passCnt++;
            if (k > 0) begin
                totalCnt++;
                if ({rv, rd0, rd1} !== ((prevW == 0) ? {2'b10, prevData, DW'(0)} : {2'b01, DW'(0), prevData}))
                    $display("FAIL contention_rdata alt=%0d k=%0d: got %b %h %h required from r%0d %h", alt, k, rv, rd0, rd1, prevW, prevData);
                else passCnt++;
            end
            prevW    = expW;
            prevData = ramInit((expW == 1) ? int'(r1_addr) : int'(r0_addr));
        end
        @(posedge clk); #1;
        r0_valid = 0;
        #3;
        g = alt ? {bR0Ready, bR1Ready} : {aR0Ready, aR1Ready};
        totalCnt++;
        if (g !== 2'b01)
            $display("FAIL contention_r0_drop alt=%0d: got %b required 01", alt, g);
        else passCnt++;
        r1_valid = 0;
    endtask

    task automatic test_reset_midread();
        applyReset();
        @(posedge clk); #1;
        r1_valid = 1; r1_addr = 4'd2; r1_wstrb = 2'b00;
        @(posedge clk); #1;
        r1_addr = 4'd9;
        #3;
        totalCnt++;
        if ({aR0Ready, aR1Ready} !== 2'b01)
            $display("FAIL midread_grant: got %b required 01", {aR0Ready, aR1Ready});
        else passCnt++;
        #1 rst = 1'b1;
        @(posedge clk); #1;
        totalCnt++;
        if ({aR1Rvalid, aR1Ready, aRamEn} !== 3'b000)
            $display("FAIL midread_dropped: got %b required 000", {aR1Rvalid, aR1Ready, aRamEn});
        else passCnt++;
        #1 rst = 1'b0;
        r0_valid = 1; r0_addr = 4'd4; r0_wstrb = 2'b00;
        #1;
        totalCnt++;
        if ({aR0Ready, aR1Ready, aR1Rvalid} !== 3'b100)
            $display("FAIL midread_contended: got %b required 100", {aR0Ready, aR1Ready, aR1Rvalid});
        else passCnt++;
        @(posedge clk); #1;
        r0_valid = 0; r1_valid = 0;
        totalCnt++;
        if ({aR0Rvalid, aR1Rvalid, aR0Rdata} !== {1'b1, 1'b0, ramInit(4)})
            $display("FAIL midread_next_read: got %b %b %h required 1 0 %h", aR0Rvalid, aR1Rvalid, aR0Rdata, ramInit(4));
        else passCnt++;
    endtask

    task automatic test_random(input int n);
        bit            p0 = 0;
        bit            p1 = 0;
        int            w;
        bit            v0, v1;
        logic [AW-1:0] ea;
        logic [NC-1:0] es;
        logic [DW-1:0] ed;
        applyReset();
        mb = 4;
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            if (!p0 && $urandom_range(0, 3) != 0) begin
                p0 = 1; r0_addr = AW'($urandom); r0_wdata = DW'($urandom);
                r0_wstrb = ($urandom_range(0, 1) == 1) ? '0 : NC'($urandom);
            end
            if (!p1 && $urandom_range(0, 3) != 0) begin
                p1 = 1; r1_addr = AW'($urandom); r1_wdata = DW'($urandom);
                r1_wstrb = ($urandom_range(0, 1) == 1) ? '0 : NC'($urandom);
            end
            r0_valid = p0 && ($urandom_range(0, 15) != 0);
            r1_valid = p1 && ($urandom_range(0, 15) != 0);
            #3;
            w = expWinner(r0_valid, r1_valid);
            totalCnt++;
            if ({aR0Ready, aR1Ready, aRamEn} !== {w == 0, w == 1, w >= 0})
                $display("FAIL rand_grant k=%0d: got %b required %b", k, {aR0Ready, aR1Ready, aRamEn}, {w == 0, w == 1, w >= 0});
            else passCnt++;
            if (w >= 0) begin
                ea = (w == 1) ? r1_addr : r0_addr;
                es = (w == 1) ? r1_wstrb : r0_wstrb;
                ed = (w == 1) ? r1_wdata : r0_wdata;
                totalCnt++;
                if ({aRamAddr, aRamWe, aRamDin} !== {ea, es, ed})
                    $display("FAIL rand_ram k=%0d: got %h %b %h required %h %b %h", k, aRamAddr, aRamWe, aRamDin, ea, es, ed);
                else passCnt++;
            end
            v0 = pendV && pendId == 0;
            v1 = pendV && pendId == 1;
            totalCnt++;
            if ({aR0Rvalid, aR1Rvalid, aR0Rdata, aR1Rdata} !== {v0, v1, v0 ? pendData : DW'(0), v1 ? pendData : DW'(0)})
                $display("FAIL rand_rdata k=%0d: got %b %b %h %h required %b %b data %h", k, aR0Rvalid, aR1Rvalid, aR0Rdata, aR1Rdata, v0, v1, pendData);
            else passCnt++;
            if (w == 0) begin
                modelAccept(w, r0_addr, r0_wdata, r0_wstrb); p0 = 0;
            end else if (w == 1) begin
                modelAccept(w, r1_addr, r1_wdata, r1_wstrb); p1 = 0;
            end else begin
                modelAccept(-1, '0, '0, '0);
            end
        end
        r0_valid = 0; r1_valid = 0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passCnt, totalCnt);
        $fatal(1);
    end

    initial begin
        r0_valid = 0; r1_valid = 0;
        r0_addr = '0; r1_addr = '0; r0_wdata = '0; r1_wdata = '0; r0_wstrb = '0; r1_wstrb = '0;
        mb = 4;
        test_reset();
        test_byte_enables();
        test_contention(1'b0);
        test_contention(1'b1);
        test_reset_midread();
        test_random(400);
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end
endmodule
